mul_arb: RTL and testbench
==========================

MUL_ARB -- requirements
Module: mul_arb

Interface
REQ-001 SHALL have parameter M, default 26, multiplicand width (unsigned).
REQ-002 SHALL have parameter N, default 13, multiplier width (unsigned).
REQ-003 SHALL have parameter NREQ, default 2, number of requesters (2..4).
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous reset, active-low.
REQ-006 SHALL have port req_valid  in  NREQ  per-requester operation request.
REQ-007 SHALL have port req_ready  out  NREQ  per-requester accept, one-hot or zero.
REQ-008 SHALL have port req_a  in  NREQ*M  flattened multiplicands, slot i at [i*M +: M].
REQ-009 SHALL have port req_b  in  NREQ*N  flattened multipliers, slot i at [i*N +: N].
REQ-010 SHALL have port res_valid  out  NREQ  one-cycle result pulse to the owning requester.
REQ-011 SHALL have port res_data  out  M+N  shared result bus, valid only with res_valid.
REQ-012 SHALL have ports mul_en, mul_a (M), mul_b (N)  out  drive the shared shift-add multiplier.
REQ-013 SHALL have ports mul_product (M+N), mul_ok (1)  in  multiplier result and completion flag.

Function
REQ-014 SHALL implement FSM IDLE -> RUN -> DONE -> RECOV -> IDLE.
REQ-015 IDLE: any req_valid high -> assert req_ready for the round-robin winner that same cycle; on that edge capture the winner's operands and index; go to RUN.
REQ-016 Round-robin: the requester after the last granted one has priority; after reset requester 0 has priority.
REQ-017 RUN: mul_en=1; mul_a/mul_b SHALL hold the captured operands unchanged for the whole RUN (the multiplier samples multiplier bits every cycle).
REQ-018 RUN -> DONE when mul_ok is sampled high; capture mul_product into res_data.
REQ-019 DONE: res_valid[owner]=1 for exactly one cycle; mul_en=0; go to RECOV.
REQ-020 RECOV: mul_en=0 for 2 cycles (counter), guaranteeing mul_ok has cleared before reissue; then IDLE.
REQ-021 mul_ok high outside RUN SHALL be ignored.
REQ-022 Request accept to res_valid SHALL take N+4 cycles with the standard multiplier; back-to-back issue interval N+7 cycles.
REQ-023 req_ready SHALL be 0 in RUN, DONE and RECOV; requests wait, not dropped; req_valid may drop before grant without side effects.
REQ-024 res_data SHALL hold its value until the next capture.

Reset
REQ-025 On rst_n low: state IDLE, req_ready=0, res_valid=0, res_data=0, mul_en=0, mul_a=0, mul_b=0, RR pointer to requester 0, RECOV counter 0.
REQ-026 Reset mid-operation SHALL abort the operation silently; no res_valid for it.

Configuration
REQ-027 Macro MUL_ARB_TIMEOUT_EN, when defined, SHALL add output res_err (1) and a watchdog: RUN lasting more than N+8 cycles -> DONE with res_valid[owner]=1, res_err=1, res_data=0.
REQ-028 Without MUL_ARB_TIMEOUT_EN: no res_err port, no watchdog; RUN waits indefinitely.

Structure
REQ-029 Package mul_arb_pkg SHALL hold FSM state encoding, RECOV length (2) and timeout margin (8).
REQ-030 Sub-module mul_arb_rr SHALL implement the NREQ-way round-robin grant (req, pointer -> one-hot grant).

Verification
REQ-031 req 0: a=3, b=5 -> res_valid[0] after N+4 cycles, res_data=15.
REQ-032 req 1: a=2^26-1, b=2^13-1 -> res_data=0x7FFBFFE001 (full-width product, no truncation).
REQ-033 req_valid=2'b11 held for 4 ops -> grants 0,1,0,1; each res_valid to the correct requester.
REQ-034 rst_n low 5 cycles into RUN -> mul_en=0, no res_valid; next request completes correctly.
REQ-035 MUL_ARB_TIMEOUT_EN defined, mul_ok tied 0 -> res_valid and res_err high N+9 cycles after grant, res_data=0.
REQ-036 a=0, b=8191 and a=67108863, b=0 -> res_data=0 both times.

Source files
------------

// File: rtl/mul_arb_pkg.sv
// Shared definitions for the mul_arb shared-multiplier arbiter:
// FSM state encoding, recovery length and watchdog margin.
package mul_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2,
    ST_RECOV = 2'd3
  } mul_arb_state_e;

  localparam int RECOV_LEN      = 2;
  localparam int RECOV_CW       = 2;
  localparam int TIMEOUT_MARGIN = 8;

  // Width of an index able to address NREQ (2..4) requesters.
  function automatic int idx_width(input int nreq);
    return (nreq > 2) ? 2 : 1;
  endfunction

endpackage

// File: rtl/mul_arb_rr.sv
// Round-robin grant: the requester at index ptr has highest priority,
// then ptr+1, ... wrapping around; output is one-hot (or zero) plus its index.
module mul_arb_rr
  import mul_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx
);

  localparam int SW = IW + 1;

  logic [SW-1:0] sum_s;
  logic [IW-1:0] idx_s;
  logic          found_s;
  logic          hit_s;

  // Scan requesters starting at the pointer; first active one wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found_s = 1'b0;
    sum_s   = '0;
    idx_s   = '0;
    hit_s   = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      sum_s   = {1'b0, ptr} + SW'(off);
      idx_s   = (sum_s >= SW'(NREQ)) ? IW'(sum_s - SW'(NREQ)) : IW'(sum_s);
      hit_s   = !found_s && req[idx_s];
      gnt[idx_s] = gnt[idx_s] | hit_s;
      gnt_idx = hit_s ? idx_s : gnt_idx;
      found_s = found_s | hit_s;
    end
  end

endmodule

// File: rtl/mul_arb.sv
// Arbitrates NREQ requesters onto one shared shift-add multiplier.
// Optional macro MUL_ARB_TIMEOUT_EN adds a RUN watchdog and the res_err output.
module mul_arb
  import mul_arb_pkg::*;
#(
  parameter int M    = 26,
  parameter int N    = 13,
  parameter int NREQ = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*M-1:0]   req_a,
  input  logic [NREQ*N-1:0]   req_b,
  output logic [NREQ-1:0]     res_valid,
  output logic [M+N-1:0]      res_data,
`ifdef MUL_ARB_TIMEOUT_EN
  output logic                res_err,
`endif
  output logic                mul_en,
  output logic [M-1:0]        mul_a,
  output logic [N-1:0]        mul_b,
  input  logic [M+N-1:0]      mul_product,
  input  logic                mul_ok
);

  localparam int IW = idx_width(NREQ);
  localparam logic [RECOV_CW-1:0] RECOV_LAST = RECOV_CW'(RECOV_LEN - 1);
  localparam logic [IW-1:0]       LAST_REQ   = IW'(NREQ - 1);

`ifdef MUL_ARB_TIMEOUT_EN
  localparam int RCW = $clog2(N + TIMEOUT_MARGIN + 1);
  localparam logic [RCW-1:0] RUN_LAST = RCW'(N + TIMEOUT_MARGIN - 1);
`endif

  mul_arb_state_e        state_q, state_d;
  logic [IW-1:0]         owner_q, owner_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [M-1:0]          opa_q, opa_d;
  logic [N-1:0]          opb_q, opb_d;
  logic                  mul_en_q, mul_en_d;
  logic [NREQ-1:0]       res_valid_q, res_valid_d;
  logic [M+N-1:0]        res_data_q, res_data_d;
  logic [RECOV_CW-1:0]   recov_q, recov_d;
  logic                  rdy_q, rdy_d;
`ifdef MUL_ARB_TIMEOUT_EN
  logic [RCW-1:0]        run_cnt_q, run_cnt_d;
  logic                  err_q, err_d;
`endif

  logic [NREQ-1:0]       gnt_s;
  logic [IW-1:0]         gnt_idx_s;
  logic [NREQ-1:0]       owner_oh_s;

  mul_arb_rr #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s)
  );

  // Grant is visible in the same IDLE cycle; rdy_q keeps it low out of reset.
  always_comb begin
    req_ready = '0;
    if (rdy_q && (state_q == ST_IDLE)) begin
      req_ready = gnt_s;
    end else begin
      req_ready = '0;
    end
  end

  // One-hot decode of the captured owner for the result pulse.
  always_comb begin
    owner_oh_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      owner_oh_s[i] = (owner_q == IW'(i));
    end
  end

  // Next-state and next-output computation for the arbiter FSM.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    mul_en_d    = 1'b0;
    res_valid_d = '0;
    res_data_d  = res_data_q;
    recov_d     = recov_q;
    rdy_d       = 1'b0;
`ifdef MUL_ARB_TIMEOUT_EN
    run_cnt_d   = run_cnt_q;
    err_d       = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|req_ready) begin
          owner_d  = gnt_idx_s;
          ptr_d    = (gnt_idx_s == LAST_REQ) ? '0 : gnt_idx_s + IW'(1);
          for (int i = 0; i < NREQ; i++) begin
            opa_d = gnt_s[i] ? req_a[i*M +: M] : opa_d;
            opb_d = gnt_s[i] ? req_b[i*N +: N] : opb_d;
          end
          mul_en_d = 1'b1;
          state_d  = ST_RUN;
`ifdef MUL_ARB_TIMEOUT_EN
          run_cnt_d = '0;
`endif
        end else begin
          rdy_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (mul_ok) begin
          res_data_d  = mul_product;
          res_valid_d = owner_oh_s;
          state_d     = ST_DONE;
        end
`ifdef MUL_ARB_TIMEOUT_EN
        else if (run_cnt_q == RUN_LAST) begin
          res_data_d  = '0;
          res_valid_d = owner_oh_s;
          err_d       = 1'b1;
          state_d     = ST_DONE;
        end
`endif
        else begin
          mul_en_d = 1'b1;
`ifdef MUL_ARB_TIMEOUT_EN
          run_cnt_d = run_cnt_q + RCW'(1);
`endif
        end
      end
      ST_DONE: begin
        recov_d = '0;
        state_d = ST_RECOV;
      end
      ST_RECOV: begin
        // Hold mul_en low long enough for the multiplier to drop mul_ok.
        if (recov_q == RECOV_LAST) begin
          recov_d = '0;
          rdy_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          recov_d = recov_q + RECOV_CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        recov_d = '0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      ptr_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      mul_en_q    <= 1'b0;
      res_valid_q <= '0;
      res_data_q  <= '0;
      recov_q     <= '0;
      rdy_q       <= 1'b0;
`ifdef MUL_ARB_TIMEOUT_EN
      run_cnt_q   <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      mul_en_q    <= mul_en_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      recov_q     <= recov_d;
      rdy_q       <= rdy_d;
`ifdef MUL_ARB_TIMEOUT_EN
      run_cnt_q   <= run_cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign mul_en    = mul_en_q;
  assign mul_a     = opa_q;
  assign mul_b     = opb_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
`ifdef MUL_ARB_TIMEOUT_EN
  assign res_err   = err_q;
`endif

endmodule

// File: tb/tb_mul_arb.sv
// Directed bench for mul_arb with a behavioural shift-add multiplier
// (load + N shifts + registered done flag).
`timescale 1ns/1ps
module tb_mul_arb;

  localparam int M    = 26;
  localparam int N    = 13;
  localparam int NREQ = 2;
  localparam int W    = M + N;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*M-1:0] req_a = '0;
  logic [NREQ*N-1:0] req_b = '0;
  logic [NREQ-1:0]   res_valid;
  logic [W-1:0]      res_data;
  logic              mul_en;
  logic [M-1:0]      mul_a;
  logic [N-1:0]      mul_b;
  logic [W-1:0]      mul_product;
  logic              mul_ok;
`ifdef MUL_ARB_TIMEOUT_EN
  logic              res_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mul_arb #(.M(M), .N(N), .NREQ(NREQ)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .res_valid   (res_valid),
    .res_data    (res_data),
`ifdef MUL_ARB_TIMEOUT_EN
    .res_err     (res_err),
`endif
    .mul_en      (mul_en),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_product (mul_product),
    .mul_ok      (mul_ok)
  );

  // Multiplier model: mul_ok rises after N+2 enabled cycles, clears when disabled.
  logic [5:0]   m_cnt;
  logic         m_ok;
  logic [W-1:0] m_prod;
  logic [M-1:0] a_ld;
  logic [N-1:0] b_ld;
  logic         hold_err;
  logic         m_stall = 1'b0;
  logic         ok_inject = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= '0; m_ok <= 1'b0; m_prod <= '0;
      a_ld <= '0; b_ld <= '0; hold_err <= 1'b0;
    end else if (!mul_en) begin
      m_cnt <= '0; m_ok <= 1'b0;
    end else begin
      if (m_cnt == 6'd0) begin
        m_prod <= W'(mul_a) * W'(mul_b);
        a_ld <= mul_a; b_ld <= mul_b;
      end else if (mul_a != a_ld || mul_b != b_ld) begin
        hold_err <= 1'b1;
      end
      if (!m_stall && m_cnt == 6'(N + 1)) m_ok <= 1'b1;
      if (m_cnt != 6'd63) m_cnt <= m_cnt + 6'd1;
    end
  end

  assign mul_ok      = m_ok | ok_inject;
  assign mul_product = m_prod;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [M-1:0] a, input logic [N-1:0] b);
    req_a[i*M +: M] = a;
    req_b[i*N +: N] = b;
    req_valid[i]    = 1'b1;
  endtask

  task automatic run_op(input string tag, input int i, input logic [M-1:0] a,
                        input logic [N-1:0] b, input logic [W-1:0] exp);
    int k;
    logic [NREQ-1:0] oh;
    oh = NREQ'(1) << i;
    @(negedge clk);
    set_req(i, a, b);
    #1;
    check_eq({tag, "_ready"}, 64'(req_ready), 64'(oh));
    @(negedge clk);
    req_valid = '0;
    k = 1;
    while (res_valid == '0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_latency"}, 64'(k), 64'(N + 4));
    check_eq({tag, "_owner"}, 64'(res_valid), 64'(oh));
    check_eq({tag, "_data"}, 64'(res_data), 64'(exp));
    @(negedge clk);
    check_eq({tag, "_pulse"}, 64'(res_valid), 64'd0);
    check_eq({tag, "_hold"}, 64'(res_data), 64'(exp));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "tb_mul_arb timeout");
  end

  initial begin
    int k;
    int k2;
    int hits;
    logic [NREQ-1:0] exp_oh;

    // Reset state, with requests present to show no grant leaks out.
    req_valid = 2'b11;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", 64'(req_ready), 64'd0);
    check_eq("rst_mul_en", 64'(mul_en), 64'd0);
    check_eq("rst_mul_a", 64'(mul_a), 64'd0);
    check_eq("rst_mul_b", 64'(mul_b), 64'd0);
    check_eq("rst_res_valid", 64'(res_valid), 64'd0);
    check_eq("rst_res_data", 64'(res_data), 64'd0);
    req_valid = '0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_op("op0", 0, 26'd3, 13'd5, 39'd15);
    run_op("op1", 1, 26'h3FFFFFF, 13'h1FFF, 39'h7FFBFFE001);

    // Both requesters held valid: expect alternating grants N+7 apart.
    @(negedge clk);
    req_a = {26'd100, 26'd7};
    req_b = {13'd3, 13'd9};
    req_valid = 2'b11;
    for (int op = 0; op < 4; op++) begin
      exp_oh = NREQ'(1) << (op % 2);
      #1;
      check_eq("rr_grant", 64'(req_ready), 64'(exp_oh));
      k = 0;
      do begin
        @(negedge clk);
        k++;
        if (k == 1) check_eq("rr_busy_ready", 64'(req_ready), 64'd0);
      end while (res_valid == '0 && k < 60);
      check_eq("rr_latency", 64'(k), 64'(N + 4));
      check_eq("rr_owner", 64'(res_valid), 64'(exp_oh));
      check_eq("rr_data", 64'(res_data), (op % 2 == 0) ? 64'd63 : 64'd300);
      if (op == 3) begin
        req_valid = '0;
      end else begin
        k2 = 0;
        while (req_ready == '0 && k2 < 10) begin
          @(negedge clk);
          k2++;
        end
        check_eq("rr_interval", 64'(k + k2), 64'(N + 7));
      end
    end
    repeat (4) @(negedge clk);
    check_eq("operand_hold", 64'(hold_err), 64'd0);

    // Reset five cycles into RUN aborts silently.
    set_req(1, 26'd11, 13'd11);
    @(negedge clk);
    req_valid = '0;
    repeat (4) @(negedge clk);
    check_eq("pre_abort_mul_en", 64'(mul_en), 64'd1);
    rst_n = 1'b0;
    req_valid = 2'b11;
    #1;
    check_eq("abort_mul_en", 64'(mul_en), 64'd0);
    check_eq("abort_res_valid", 64'(res_valid), 64'd0);
    check_eq("abort_res_data", 64'(res_data), 64'd0);
    check_eq("abort_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;
    hits = 0;
    for (int c = 0; c < N + 8; c++) begin
      @(negedge clk);
      if (res_valid != '0) hits++;
    end
    check_eq("abort_no_result", 64'(hits), 64'd0);
    run_op("after_abort", 0, 26'd1000, 13'd1000, 39'd1000000);

    run_op("zero_a", 0, 26'd0, 13'd8191, 39'd0);
    run_op("zero_b", 1, 26'd67108863, 13'd0, 39'd0);

    // Spurious mul_ok while idle must be ignored.
    ok_inject = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("stray_ok_res_valid", 64'(res_valid), 64'd0);
      check_eq("stray_ok_mul_en", 64'(mul_en), 64'd0);
    end
    ok_inject = 1'b0;
    repeat (2) @(negedge clk);
    run_op("post_stray", 1, 26'd12345, 13'd77, 39'd950565);

`ifdef MUL_ARB_TIMEOUT_EN
    // Multiplier never completes: watchdog returns an error result.
    m_stall = 1'b1;
    @(negedge clk);
    set_req(0, 26'd5, 13'd5);
    @(negedge clk);
    req_valid = '0;
    k = 1;
    while (res_valid == '0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    check_eq("to_latency", 64'(k), 64'(N + 9));
    check_eq("to_owner", 64'(res_valid), 64'd1);
    check_eq("to_err", 64'(res_err), 64'd1);
    check_eq("to_data", 64'(res_data), 64'd0);
    @(negedge clk);
    check_eq("to_err_pulse", 64'(res_err), 64'd0);
    m_stall = 1'b0;
    repeat (2) @(negedge clk);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
